// File: rtl/nic_pkg.sv
// Shared parameters and register-address map for the processor/router NIC.
package nic_pkg;

    // Packet and processor data width, and the position of the virtual-channel bit.
    localparam int DATA_WIDTH = 64;
    localparam int VC_BIT     = 0;

    // Memory-mapped register select values seen on addr.
    localparam logic [1:0] NIC_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry channel buffer: a data register plus a full flag.
// Drain wins over load when both are requested on the same edge.
module nic_channel_buffer #(
    parameter int WIDTH = nic_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic [0:WIDTH-1] d,
    output logic [0:WIDTH-1] q,
    output logic             full
);

    // Capture on load, release on drain; contents cleared on reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: the data register is reset too, so a stale read right after reset returns zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (drain) begin
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_nic.sv
// Processor <-> mesh-router network interface: one-entry buffer per direction,
// memory-mapped status flags, and VC-polarity gated outbound injection.
module cpu_nic #(
    parameter int DATA_WIDTH = nic_pkg::DATA_WIDTH,
    parameter int VC_BIT     = nic_pkg::VC_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di
);

    import nic_pkg::*;

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  rd_en;
    logic                  wr_en;
    logic                  in_load;
    logic                  in_drain;
    logic                  out_load;
    logic                  inject;

    // Access decode and channel handshakes, all from pre-edge flags.
    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        in_load  = 1'b0;
        in_drain = 1'b0;
        out_load = 1'b0;
        inject   = 1'b0;
        rd_en    = nicEn & ~nicWrEn;
        wr_en    = nicEn & nicWrEn;
        // Router packets are only taken while the input buffer is empty.
        in_load  = net_si & ~in_full;
        // Reading an empty input buffer must not swallow a packet arriving on that edge.
        in_drain = rd_en & (addr == NIC_IN_BUF) & in_full;
        // A write to a full output buffer is dropped rather than overwriting it.
        out_load = wr_en & (addr == NIC_OUT_BUF) & ~out_full;
        // Inject only into the router's opposite VC phase.
        inject   = out_full & net_ro & (out_buf[VC_BIT] == ~net_polarity);
    end

    assign net_ri = ~in_full;

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_chan (
        .clk   (clk),
        .reset (reset),
        .load  (in_load),
        .drain (in_drain),
        .d     (net_di),
        .q     (in_buf),
        .full  (in_full)
    );

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_chan (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .drain (inject),
        .d     (d_in),
        .q     (out_buf),
        .full  (out_full)
    );

    // Registered processor read port; holds its value when not reading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                NIC_IN_BUF:   d_out <= in_buf;
                NIC_IN_STAT:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                NIC_OUT_BUF:  d_out <= '0;
                default:      d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
            endcase
        end
    end

    // One-cycle send strobe with the packet; net_do keeps the last packet sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_so <= 1'b0;
            net_do <= '0;
        end else begin
            net_so <= inject;
            if (inject) begin
                net_do <= out_buf;
            end
        end
    end

endmodule

// File: tb/tb_cpu_nic.sv
// Self-checking bench for cpu_nic: directed vector table, reset corner case,
// then randomized traffic against a queue-based reference model.
module tb_cpu_nic;

    localparam int DW = 64;
    localparam int VB = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_polarity;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;

    int checks = 0;
    int errors = 0;

    cpu_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_inq[$];
    logic [DW-1:0] m_outq[$];
    logic [DW-1:0] m_in_last;
    logic [DW-1:0] m_dout;
    logic          m_so;
    logic [DW-1:0] m_do;

    // VC bit of a packet whose bit 0 is the most significant bit.
    function automatic logic vc_of(input logic [DW-1:0] pkt);
        return 1'((pkt >> (DW - 1 - VB)) & 64'd1);
    endfunction

    task automatic model_reset();
        m_inq.delete();
        m_outq.delete();
        m_in_last = '0;
        m_dout    = '0;
        m_so      = 1'b0;
        m_do      = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        bit in_full_pre  = (m_inq.size() != 0);
        bit out_full_pre = (m_outq.size() != 0);
        bit rd = nicEn && !nicWrEn;
        bit wr = nicEn && nicWrEn;
        bit send;
        if (rd) begin
            case (addr)
                2'd0: m_dout = in_full_pre ? m_inq[0] : m_in_last;
                2'd1: m_dout = 64'(in_full_pre);
                2'd2: m_dout = '0;
                default: m_dout = 64'(out_full_pre);
            endcase
        end
        send = out_full_pre && net_ro && (vc_of(m_outq[0]) != net_polarity);
        m_so = send;
        if (send) m_do = m_outq.pop_front();
        if (wr && addr == 2'd2 && !out_full_pre) m_outq.push_back(d_in);
        if (rd && addr == 2'd0 && in_full_pre) void'(m_inq.pop_front());
        if (net_si && !in_full_pre) begin
            m_inq.push_back(net_di);
            m_in_last = net_di;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [DW-1:0] din,
                         input logic ro, input logic pol, input logic si, input logic [DW-1:0] di);
        nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
    endtask

    typedef struct {
        logic          en;
        logic          wr;
        logic [1:0]    a;
        logic [DW-1:0] din;
        logic          ro;
        logic          pol;
        logic          si;
        logic [DW-1:0] di;
        logic [DW-1:0] e_dout;
        logic          e_so;
        logic [DW-1:0] e_do;
        logic          e_ri;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic wr, input logic [1:0] a, input logic [DW-1:0] din,
                       input logic ro, input logic pol, input logic si, input logic [DW-1:0] di,
                       input logic [DW-1:0] e_dout, input logic e_so, input logic [DW-1:0] e_do, input logic e_ri);
        vec_t v;
        v.en = en; v.wr = wr; v.a = a; v.din = din; v.ro = ro; v.pol = pol; v.si = si; v.di = di;
        v.e_dout = e_dout; v.e_so = e_so; v.e_do = e_do; v.e_ri = e_ri;
        tbl.push_back(v);
    endtask

    localparam logic [DW-1:0] PAB = 64'h0000_0000_0000_00AB;
    localparam logic [DW-1:0] PV1 = 64'h8000_0000_0000_0012;
    localparam logic [DW-1:0] PDB = 64'h0000_0000_DEAD_BEEF;
    localparam logic [DW-1:0] PCF = 64'h0000_0000_0000_CAFE;

    initial begin
        model_reset();
        reset = 1'b0;
        drive(0, 0, 2'd0, '0, 0, 0, 0, '0);
        #12;
        check("reset d_out", d_out, '0);
        check("reset net_so", 64'(net_so), 64'd0);
        check("reset net_do", net_do, '0);
        check("reset net_ri", 64'(net_ri), 64'd1);
        tick();
        reset = 1'b1;

        // en wr a   din      ro pol si di     | d_out   so  net_do ri
        add(1, 0, 1, '0,      0, 0, 0, '0,     '0,     0, '0,   1); // 1  status in
        add(1, 0, 3, '0,      0, 0, 0, '0,     '0,     0, '0,   1); // 2  status out
        add(1, 1, 2, PAB,     0, 1, 0, '0,     '0,     0, '0,   1); // 3  write out
        add(1, 0, 3, '0,      0, 1, 0, '0,     64'd1,  0, '0,   1); // 4  out_full=1
        add(0, 0, 0, '0,      1, 1, 0, '0,     64'd1,  1, PAB,  1); // 5  inject
        add(0, 0, 0, '0,      1, 1, 0, '0,     64'd1,  0, PAB,  1); // 6  strobe is one cycle
        add(1, 0, 3, '0,      1, 1, 0, '0,     '0,     0, PAB,  1); // 7  out_full=0
        add(1, 1, 2, PAB,     1, 0, 0, '0,     '0,     0, PAB,  1); // 8  write, VC mismatch
        add(0, 0, 0, '0,      1, 0, 0, '0,     '0,     0, PAB,  1); // 9  held
        add(0, 0, 0, '0,      1, 0, 0, '0,     '0,     0, PAB,  1); // 10 held
        add(1, 0, 3, '0,      1, 0, 0, '0,     64'd1,  0, PAB,  1); // 11 still full
        add(0, 0, 0, '0,      1, 1, 0, '0,     64'd1,  1, PAB,  1); // 12 polarity toggles: send
        add(0, 0, 0, '0,      1, 1, 0, '0,     64'd1,  0, PAB,  1); // 13 only once
        add(1, 1, 2, PV1,     1, 0, 0, '0,     64'd1,  0, PAB,  1); // 14 write VC=1 packet
        add(0, 0, 0, '0,      1, 0, 0, '0,     64'd1,  1, PV1,  1); // 15 send next edge
        add(0, 0, 0, '0,      0, 0, 1, PDB,    64'd1,  0, PV1,  0); // 16 router packet in
        add(1, 0, 1, '0,      0, 0, 1, PCF,    64'd1,  0, PV1,  0); // 17 status in; 2nd held
        add(1, 0, 0, '0,      0, 0, 1, PCF,    PDB,    0, PV1,  1); // 18 read in; 2nd not taken
        add(0, 0, 0, '0,      0, 0, 1, PCF,    PDB,    0, PV1,  0); // 19 2nd accepted
        add(1, 0, 0, '0,      0, 0, 0, '0,     PCF,    0, PV1,  1); // 20 read 2nd
        add(1, 0, 0, '0,      0, 0, 0, '0,     PCF,    0, PV1,  1); // 21 empty read: stale
        add(1, 1, 2, 64'h111, 0, 0, 0, '0,     PCF,    0, PV1,  1); // 22 write first
        add(1, 1, 2, 64'h222, 0, 0, 0, '0,     PCF,    0, PV1,  1); // 23 second ignored
        add(1, 0, 3, '0,      0, 0, 0, '0,     64'd1,  0, PV1,  1); // 24 full
        add(0, 0, 0, '0,      1, 1, 0, '0,     64'd1,  1, 64'h111, 1); // 25 first value sent
        add(1, 1, 0, 64'h555, 0, 0, 0, '0,     64'd1,  0, 64'h111, 1); // 26 write 00 ignored
        add(1, 1, 3, 64'h777, 0, 0, 0, '0,     64'd1,  0, 64'h111, 1); // 27 write 11 ignored
        add(1, 0, 2, '0,      0, 0, 0, '0,     '0,     0, 64'h111, 1); // 28 read 10 -> 0
        add(1, 0, 3, '0,      0, 0, 0, '0,     '0,     0, 64'h111, 1); // 29
        add(1, 0, 1, '0,      0, 0, 0, '0,     '0,     0, 64'h111, 1); // 30
        add(1, 1, 2, 64'h333, 0, 1, 0, '0,     '0,     0, 64'h111, 1); // 31
        add(1, 0, 3, '0,      1, 1, 0, '0,     64'd1,  1, 64'h333, 1); // 32 status pre-edge
        add(1, 0, 3, '0,      0, 1, 0, '0,     '0,     0, 64'h333, 1); // 33
        add(1, 1, 2, 64'h444, 0, 1, 0, '0,     '0,     0, 64'h333, 1); // 34
        add(1, 1, 2, 64'h999, 1, 1, 0, '0,     '0,     1, 64'h444, 1); // 35 write on inject ignored
        add(1, 0, 3, '0,      0, 1, 0, '0,     '0,     0, 64'h444, 1); // 36 buffer empty

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].a, tbl[i].din, tbl[i].ro, tbl[i].pol, tbl[i].si, tbl[i].di);
            model_step();
            tick();
            check($sformatf("row%0d d_out", i + 1), d_out, tbl[i].e_dout);
            check($sformatf("row%0d net_so", i + 1), 64'(net_so), 64'(tbl[i].e_so));
            check($sformatf("row%0d net_do", i + 1), net_do, tbl[i].e_do);
            check($sformatf("row%0d net_ri", i + 1), 64'(net_ri), 64'(tbl[i].e_ri));
        end

        // Reset while both buffers are full: outputs clear without a clock edge.
        drive(1, 1, 2, 64'hF00, 0, 1, 1, 64'hBEE);
        tick();
        drive(1, 0, 3, '0, 0, 1, 0, '0);
        tick();
        check("pre-reset d_out", d_out, 64'd1);
        check("pre-reset net_ri", 64'(net_ri), 64'd0);
        reset = 1'b0;
        #1;
        check("async d_out", d_out, '0);
        check("async net_so", 64'(net_so), 64'd0);
        check("async net_do", net_do, '0);
        check("async net_ri", 64'(net_ri), 64'd1);
        model_reset();
        tick();
        reset = 1'b1;
        drive(1, 0, 3, '0, 1, 1, 0, '0);
        model_step();
        tick();
        check("post-reset out stat", d_out, '0);
        check("post-reset net_so", 64'(net_so), 64'd0);
        drive(1, 0, 1, '0, 0, 0, 0, '0);
        model_step();
        tick();
        check("post-reset in stat", d_out, '0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [DW-1:0] pkt;
            logic [DW-1:0] rin;
            pkt = {$urandom(), $urandom()};
            rin = {$urandom(), $urandom()};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), pkt,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, rin);
            model_step();
            tick();
            check($sformatf("rnd%0d d_out", n), d_out, m_dout);
            check($sformatf("rnd%0d net_so", n), 64'(net_so), 64'(m_so));
            check($sformatf("rnd%0d net_do", n), net_do, m_do);
            check($sformatf("rnd%0d net_ri", n), 64'(net_ri), 64'(m_inq.size() == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_nic.md
# cpu_nic

Network interface between the four-stage processor's NIC port and the local mesh router port. It holds a one-entry output channel buffer that the processor fills and the router drains, plus a one-entry input channel buffer that the router fills and the processor drains. Both directions expose memory-mapped status flags, and outbound injection is gated by the router's virtual-channel polarity. The processor reaches the NIC with `ld`/`sd` instructions whose immediate address has bits [0:1] = 2'b11.

## Interface
- `DATA_WIDTH`, default 64: packet and processor data width.
- `VC_BIT`, default 0: index of the virtual-channel bit within a packet.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `d_in`  in  [0:DATA_WIDTH-1]  write data from processor.
- `d_out`  out  [0:DATA_WIDTH-1]  read data to processor (registered).
- `nicEn`  in  1  access enable.
- `nicWrEn`  in  1  write when 1, read when 0 (only meaningful while `nicEn`=1).
- `net_so`  out  1  send strobe to router.
- `net_ro`  in  1  router ready to accept.
- `net_do`  out  [0:DATA_WIDTH-1]  packet to router.
- `net_polarity`  in  1  router's current external VC phase.
- `net_si`  in  1  router send strobe into NIC.
- `net_ri`  out  1  NIC ready to accept from router.
- `net_di`  in  [0:DATA_WIDTH-1]  packet from router.

## Operation
- State:
  - `in_buf`/`in_full` and `out_buf`/`out_full`.
  - All clear on `reset`=0.
  - Reset output values: `d_out`=0, `net_so`=0, `net_do`=0, `net_ri`=1.
- Processor write (`nicEn`=1, `nicWrEn`=1):
  - `addr`=10 with `out_full`=0: `out_buf`<=`d_in`, `out_full`<=1.
  - `addr`=10 with `out_full`=1: ignored, buffer is not overwritten.
  - Writes to 00, 01 or 11: ignored.
- Processor read (`nicEn`=1, `nicWrEn`=0); `d_out` is loaded at the edge:
  - 00: `d_out`<=`in_buf`, `in_full`<=0. Reading while empty returns the stale `in_buf` and leaves `in_full`=0.
  - 01: `d_out`<={63'b0, `in_full`}, flag at bit 63.
  - 10: `d_out`<=0.
  - 11: `d_out`<={63'b0, `out_full`}.
- `d_out` holds its value when `nicEn`=0.
- Inbound from router:
  - `net_ri` = ~`in_full` (combinational).
  - On an edge with `net_si`=1 and `net_ri`=1: `in_buf`<=`net_di`, `in_full`<=1.
  - `net_si` while `net_ri`=0 is a router protocol violation; the packet is dropped and `in_buf` is unchanged.
- Outbound injection:
  - Condition at an edge: `out_full`=1, `net_ro`=1 and `out_buf[VC_BIT]` == ~`net_polarity`.
  - When met: `net_so`<=1 for exactly one cycle, `net_do`<=`out_buf`, `out_full`<=0.
  - Otherwise `net_so`<=0. `net_do` holds its last value.
- Simultaneous events:
  - Processor write to 10 on the same edge as injection: `out_full` sampled 1, so the write is ignored.
  - Processor read of 00 on the same edge as `net_si`: `net_ri` was 0, so the router packet is not taken; it is accepted on the next cycle once `net_ri`=1.
  - Status read on the same edge as a flag change returns the pre-edge flag.
- Reset asserted mid-operation discards both buffers immediately; there is no partial state.

## Timing
- Read latency 1 cycle: address and enable are presented in cycle N; `d_out` is valid after edge N+1 and is consumed in the processor WB stage.
- Write takes effect at the edge; `out_full` is visible to a status read issued the following cycle.
- Minimum write-to-`net_so` latency is 1 edge after the write edge when polarity matches.
- Back-to-back injections are possible every 2 cycles: write, then send.
- Inbound throughput is one packet per 2 cycles in steady state: accept, then processor read.

## Structure
- Package `nic_pkg`:
  - `DATA_WIDTH`, `VC_BIT`.
  - Address constants `NIC_IN_BUF`=2'b00, `NIC_IN_STAT`=2'b01, `NIC_OUT_BUF`=2'b10, `NIC_OUT_STAT`=2'b11.
- Sub-module `nic_channel_buffer`: one-entry register with `full` flag, `load` and `drain` inputs, drain has priority. Instantiated twice, once for input and once for output.
- Top level contains the address decode, `d_out` register, polarity gate and `net_so` register.

## Test plan
- Reset, then idle: `net_ri`=1, `net_so`=0; read 01 and 11 -> `d_out`=0 both.
- Write 64'h0000_0000_0000_00AB to 10 with `net_ro`=0 -> read 11 returns 1. Raise `net_ro` with polarity set so VC bit 0 == ~`net_polarity` -> one-cycle `net_so`, `net_do`=64'hAB, status 11 then reads 0.
- Same packet with VC mismatch -> no `net_so` until `net_polarity` toggles, then exactly one send.
- Router sends 64'hDEAD_BEEF -> `net_ri` drops next cycle. Read 01 -> 1. Read 00 -> `d_out`=64'hDEAD_BEEF, then `net_ri`=1. A second packet held on `net_si` during the full period is accepted only after the read.
- Write 10 twice without a send between -> buffer keeps the first value; the second write is ignored.
- Assert `reset` low while both buffers are full -> flags 0, `d_out` 0, `net_so` 0, `net_ri` 1 immediately, without waiting for `clk`.
